// File: rtl/sr_flag_arbiter.sv
// rtl/sr_flag_arbiter.sv - round-robin set/clear arbiter for one shared SR flag latch
module sr_flag_arbiter #(
  parameter int INIT_CYCLES  = 2,
  parameter int PULSE_CYCLES = 1
) (
  input  logic clock,
  input  logic reset_,
  input  logic req0,
  input  logic op0,
  output logic ack0,
  input  logic req1,
  input  logic op1,
  output logic ack1,
  output logic latch_preset_,
  output logic latch_preclear_,
  output logic latch_s,
  output logic latch_r,
  input  logic latch_q,
  output logic busy,
  output logic err
);

  localparam int ICW = (INIT_CYCLES < 1) ? 1 : $clog2(INIT_CYCLES + 1);
  localparam int PCW = (PULSE_CYCLES <= 2) ? 1 : $clog2(PULSE_CYCLES);

  localparam logic [ICW-1:0] INIT_LAST  = ICW'(INIT_CYCLES);
  localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_CYCLES - 1);

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_ACK   = 3'd4;

  logic [2:0]     state;
  logic [ICW-1:0] init_cnt;
  logic [PCW-1:0] pulse_cnt;
  logic           last_grant;
  logic           gnt;
  logic           op_hold;
  logic [1:0]     req_smp;
  logic [1:0]     op_smp;

  logic           pick;
  logic           pick_op;
  logic           granted_req;

  // Requests come from a 4-phase handshake; arbitration looks at a registered
  // copy so a request is sampled on one edge and granted on the next.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      req_smp <= 2'b00;
      op_smp  <= 2'b00;
    end else begin
      req_smp <= {req1, req0};
      op_smp  <= {op1, op0};
    end
  end

  // Round-robin pick: a lone request wins outright, a tie goes to whoever
  // was not served last. Release watches the live req so ack falls on the
  // edge right after the granted requester lets go.
  always_comb begin
    pick = req_smp[1];
    if (req_smp == 2'b11) begin
      pick = ~last_grant;
    end
    pick_op     = pick ? op_smp[1] : op_smp[0];
    granted_req = gnt ? req1 : req0;
  end

  // Main sequencer: init latch, grant, pulse s/r, verify q, handshake ack.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state           <= ST_INIT;
      init_cnt        <= '0;
      pulse_cnt       <= '0;
      last_grant      <= 1'b1;
      gnt             <= 1'b0;
      op_hold         <= 1'b0;
      latch_preset_   <= 1'b1;
      latch_preclear_ <= 1'b0;
      latch_s         <= 1'b0;
      latch_r         <= 1'b0;
      ack0            <= 1'b0;
      ack1            <= 1'b0;
      busy            <= 1'b1;
      err             <= 1'b0;
    end else begin
      // Preset is never exercised by this block; keep it parked high.
      latch_preset_ <= 1'b1;
      case (state)
        ST_INIT: begin
          latch_s <= 1'b0;
          latch_r <= 1'b0;
          if (init_cnt == INIT_LAST) begin
            latch_preclear_ <= 1'b1;
            busy            <= 1'b0;
            state           <= ST_IDLE;
          end else begin
            latch_preclear_ <= 1'b0;
            init_cnt        <= init_cnt + ICW'(1);
          end
        end

        ST_IDLE: begin
          if (req_smp != 2'b00) begin
            gnt       <= pick;
            op_hold   <= pick_op;
            latch_s   <= pick_op;
            latch_r   <= ~pick_op;
            pulse_cnt <= '0;
            busy      <= 1'b1;
            state     <= ST_PULSE;
          end
        end

        ST_PULSE: begin
          if (pulse_cnt == PULSE_LAST) begin
            latch_s <= 1'b0;
            latch_r <= 1'b0;
            state   <= ST_CHECK;
          end else begin
            pulse_cnt <= pulse_cnt + PCW'(1);
          end
        end

        ST_CHECK: begin
          // A wrong q only flags err; the handshake still completes so a
          // broken latch cannot hang either requester.
          if (latch_q != op_hold) begin
            err <= 1'b1;
          end
          ack0  <= ~gnt;
          ack1  <= gnt;
          state <= ST_ACK;
        end

        ST_ACK: begin
          if (!granted_req) begin
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            last_grant <= gnt;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end

        default: begin
          latch_s         <= 1'b0;
          latch_r         <= 1'b0;
          latch_preclear_ <= 1'b0;
          ack0            <= 1'b0;
          ack1            <= 1'b0;
          busy            <= 1'b1;
          init_cnt        <= '0;
          state           <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
- Two-requester controller for a single shared SR flag latch with active-low preset_/preclear_.
- Initialises the latch by holding preclear_ low after reset.
- Arbitrates round-robin between two requesters, each asking to set or clear the flag over a 4-phase req/ack handshake.
- Pulses the latch s or r input, verifies q, and returns ack; never drives s=r=1 and never drives preset_/preclear_ low together.

Parameters:
- INIT_CYCLES, 2: clock cycles preclear_ stays low after reset_ deasserts (>=1).
- PULSE_CYCLES, 1: cycles s or r stays high per operation (>=1).

Ports:
- clock, input, 1: system clock, rising edge.
- reset_, input, 1: asynchronous, active-low reset.
- req0, input, 1: requester 0 request, 4-phase.
- op0, input, 1: requester 0 operation, 1=set, 0=clear; stable while req0=1.
- ack0, output, 1: requester 0 acknowledge.
- req1, input, 1: requester 1 request.
- op1, input, 1: requester 1 operation.
- ack1, output, 1: requester 1 acknowledge.
- latch_preset_, output, 1: to latch preset_.
- latch_preclear_, output, 1: to latch preclear_.
- latch_s, output, 1: to latch s.
- latch_r, output, 1: to latch r.
- latch_q, input, 1: latch q feedback.
- busy, output, 1: 1 in any state other than IDLE.
- err, output, 1: sticky verify failure; cleared only by reset_.

Behaviour:
- Clock and reset: one clock, clock. reset_ is asynchronous and active-low.
- All outputs are registered.
- Reset values (applied immediately on reset_=0, held while low):
  - latch_preset_=1, latch_preclear_=0, latch_s=0, latch_r=0.
  - ack0=0, ack1=0, busy=1, err=0.
  - state=INIT, init counter=0, last_grant=1, so requester 0 wins the first tie.
- INIT:
  - latch_preclear_ stays 0 for INIT_CYCLES rising edges after reset_ deasserts.
  - Then latch_preclear_=1 and go to IDLE (busy=0).
  - Requests are ignored during INIT.
- IDLE:
  - No req: stay.
  - One req: grant it.
  - Both req: grant the requester that is not last_grant.
  - On grant, latch and hold the winner's op, then enter PULSE with latch_s=op, latch_r=~op, busy=1.
- PULSE:
  - Hold s/r for exactly PULSE_CYCLES cycles.
  - Then drop s=r=0 and enter CHECK.
- CHECK (one cycle):
  - Compare latch_q with the held op.
  - Mismatch: set err=1 (sticky) but still proceed, so there is no deadlock.
  - Enter ACK with ack of the granted requester=1.
- ACK:
  - Hold ack until the granted req=0.
  - Then ack=0, last_grant=granted requester, go to IDLE.
  - The other requester may be granted on the following IDLE cycle, not the same one.
- Latency: req sampled at edge E0 gives ack high after edge E0+PULSE_CYCLES+2. For the default, ack is visible 3 cycles after the sampling edge.
- Invariants checked every cycle:
  - latch_s & latch_r == 0.
  - ~latch_preset_ & ~latch_preclear_ == 0.
  - latch_preset_ == 1 always; preset is never used by this block and is tied high via a register.
  - At most one ack high.
- Requester behaviour:
  - A requester dropping req before ack is a protocol violation; the controller completes the operation and ack pulses for one cycle in ACK.
  - A req raised by the non-granted requester mid-operation is held pending and served next.
- Reset mid-operation: the sequence is abandoned immediately, s/r are forced to 0, preclear_ goes to 0, and the latch is re-initialised to q=0.

Test Plan:
- Reset then release, INIT_CYCLES=2 → latch_preclear_ low 2 edges after release, latch_q=0, busy falls to 0 on the 3rd edge; acks stay 0.
- req0=1, op0=1 → latch_s high 1 cycle, latch_q=1, ack0=1 on the 3rd edge after sampling; drop req0 → ack0=0 next edge, busy=0.
- req0 and req1 raised on the same edge, op0=1, op1=0 → requester 0 served first (ack0), then requester 1 (ack1); final latch_q=0, and the two acks never overlap.
- Repeat the simultaneous request with last_grant=0 → requester 1 served first.
- Force latch_q stuck at 0 via the bench model, req1 op1=1 → err=1 sticky, ack1 still returned; err clears only on reset_.
- Assert reset_ while latch_s=1 in PULSE → latch_s=0 and latch_preclear_=0 asynchronously, ack0=ack1=0, state=INIT.
